// File: rtl/dbg_console_pkg.sv
// Shared constants for the debug console input block: the register offsets,
// the STATUS/CONTROL bit positions, the empty-read value and the default FIFO depth.
package dbg_console_pkg;

  localparam int DEPTH_DEFAULT = 16;

  localparam logic [3:0] OFF_DATA    = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_CONTROL = 4'h8;

  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERFLOW  = 2;
  localparam int STAT_IRQ_EN    = 3;
  localparam int STAT_COUNT_LSB = 8;

  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR_OVF = 1;
  localparam int CTRL_IRQ_EN  = 2;

  localparam logic [31:0] EMPTY_READ = 32'hffffffff;

  typedef enum logic [1:0] {
    REG_DATA,
    REG_STATUS,
    REG_CONTROL,
    REG_NONE
  } regSel_e;

  // Maps the low address nibble onto a register; unmapped offsets read as zero.
  function automatic regSel_e decodeReg(input logic [3:0] offset);
    case (offset)
      OFF_DATA:    return REG_DATA;
      OFF_STATUS:  return REG_STATUS;
      OFF_CONTROL: return REG_CONTROL;
      default:     return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO holding the host characters. Pointers wrap modulo DEPTH and
// count is one bit wider than the pointers so the full level is representable.
// Flush takes priority over any push or pop in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             doPush, doPop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rdPtr_q];

  assign doPush = push_i && !full_o;
  assign doPop  = pop_i && !empty_o;

  // Next pointer and count values; a flush discards everything queued or arriving.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + 1'b1;
      if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
      count_d = count_q + CW'(doPush) - CW'(doPop);
    end
  end

  // Pointer and count state, cleared by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Character storage; contents need no reset because count guards every read.
  always_ff @(posedge clock) begin
    if (doPush && !flush_i) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/dbg_console_in.sv
// Debug console input: host characters are queued in a FIFO and read by the
// CPU through a small register window (DATA, STATUS, CONTROL).
// Optional feature macro DBG_CONSOLE_DROP_EN: the host is never back-pressured;
// characters arriving while full are dropped and flagged as a sticky overflow.
module dbg_console_in
  import dbg_console_pkg::*;
#(
  parameter int          DEPTH = DEPTH_DEFAULT,
  parameter logic [31:0] BASE  = 32'hf00000e0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        wr_i,
  output logic [31:0] data_o,
  output logic        data_access_o,
  output logic        irq_o,
  input  logic [7:0]  host_data_i,
  input  logic        host_valid_i,
  output logic        host_ready_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  regSel_e       regSel;
  logic          windowHit, isRead, dataRead, ctrlWrite, flush;
  logic          popReq, hostPush, fifoPush, hostReady, overflow;
  logic [7:0]    fifoHead;
  logic [CW-1:0] fifoCount;
  logic          fifoFull, fifoEmpty;
  logic [31:0]   statusWord, readData_d, readData_q;
  logic          prevDataRead_q, irqEn_q, irq_q, readyEn_q;
  logic          unusedDataBits;

  assign windowHit = (addr_i[31:4] == BASE[31:4]);
  assign regSel    = windowHit ? decodeReg(addr_i[3:0]) : REG_NONE;
  assign isRead    = windowHit && !wr_i;
  assign dataRead  = isRead && (regSel == REG_DATA);
  assign ctrlWrite = windowHit && wr_i && (regSel == REG_CONTROL);
  assign flush     = ctrlWrite && data_i[CTRL_FLUSH];

  // A held DATA address pops only on its first cycle, and never when empty.
  assign popReq   = dataRead && !prevDataRead_q && !fifoEmpty;
  assign hostPush = host_valid_i && hostReady;
  assign fifoPush = hostPush && !fifoFull;

`ifdef DBG_CONSOLE_DROP_EN
  logic overflow_q;
  logic dropPush;

  assign hostReady      = readyEn_q;
  assign dropPush       = hostPush && fifoFull;
  assign overflow       = overflow_q;
  assign unusedDataBits = ^data_i[31:3];

  // Sticky overflow: a new drop wins over a clear arriving in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (dropPush) begin
      overflow_q <= 1'b1;
    end else if (ctrlWrite && data_i[CTRL_CLR_OVF]) begin
      overflow_q <= 1'b0;
    end
  end
`else
  assign hostReady      = readyEn_q && !fifoFull;
  assign overflow       = 1'b0;
  assign unusedDataBits = ^{data_i[31:3], data_i[CTRL_CLR_OVF]};
`endif

  assign host_ready_o  = hostReady;
  assign data_access_o = windowHit;
  assign data_o        = readData_q;
  assign irq_o         = irq_q;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) uFifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (fifoPush),
    .pop_i   (popReq),
    .flush_i (flush),
    .data_i  (host_data_i),
    .head_o  (fifoHead),
    .count_o (fifoCount),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // Read mux sampled from the current state; non-read cycles load zero.
  always_comb begin
    statusWord = '0;
    statusWord[STAT_NOT_EMPTY] = !fifoEmpty;
    statusWord[STAT_FULL]      = fifoFull;
    statusWord[STAT_OVERFLOW]  = overflow;
    statusWord[STAT_IRQ_EN]    = irqEn_q;
    statusWord[STAT_COUNT_LSB +: CW] = fifoCount;

    readData_d = '0;
    if (isRead) begin
      case (regSel)
        REG_DATA:    readData_d = fifoEmpty ? EMPTY_READ : {24'h0, fifoHead};
        REG_STATUS:  readData_d = statusWord;
        REG_CONTROL: readData_d = {29'h0, irqEn_q, 2'b00};
        default:     readData_d = '0;
      endcase
    end
  end

  // Registered bus response, interrupt, enables and the DATA-read edge detector.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      readData_q     <= '0;
      prevDataRead_q <= 1'b0;
      irqEn_q        <= 1'b0;
      irq_q          <= 1'b0;
      readyEn_q      <= 1'b0;
    end else begin
      readData_q     <= readData_d;
      prevDataRead_q <= dataRead;
      irq_q          <= irqEn_q && !fifoEmpty;
      readyEn_q      <= 1'b1;
      if (ctrlWrite) irqEn_q <= data_i[CTRL_IRQ_EN];
    end
  end

endmodule
